// File: rtl/clock_set_ctrl.sv
// Button-driven time-setting controller: run/set-hour/set-minute mode FSM,
// increment pulses with auto-repeat, idle timeout and alarm-enable toggle.
module clock_set_ctrl #(
    parameter int unsigned REPEAT_DLY  = 8,
    parameter int unsigned REPEAT_RATE = 2,
    parameter int unsigned TIMEOUT     = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic       btn_alarm,
    input  logic       alarm_q,
    output logic [1:0] mode,
    output logic       run_en,
    output logic       blink,
    output logic       inc_hr,
    output logic       inc_min,
    output logic       alarm_s,
    output logic       alarm_r
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] DLY_LAST  = CNT_W'(REPEAT_DLY);
    localparam logic [CNT_W-1:0] DLY_RELD  = CNT_W'(REPEAT_DLY - REPEAT_RATE);
    localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        RUN     = 2'b00,
        SET_HR  = 2'b01,
        SET_MIN = 2'b10
    } state_t;

    state_t           state;
    state_t           state_nxt_c;
    logic             prev_mode;
    logic             prev_inc;
    logic             prev_alarm;
    logic [CNT_W-1:0] idle_cnt;
    logic [CNT_W-1:0] hold_cnt;

    logic mode_edge_c;
    logic inc_edge_c;
    logic alarm_edge_c;

    assign mode_edge_c  = btn_mode & ~prev_mode;
    assign inc_edge_c   = btn_inc & ~prev_inc;
    assign alarm_edge_c = btn_alarm & ~prev_alarm;

    assign mode = state;

    // Mode sequence advanced by a btn_mode edge.
    always_comb begin
        state_nxt_c = RUN;
        case (state)
            RUN:     state_nxt_c = SET_HR;
            SET_HR:  state_nxt_c = SET_MIN;
            default: state_nxt_c = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= RUN;
            run_en     <= 1'b1;
            blink      <= 1'b0;
            inc_hr     <= 1'b0;
            inc_min    <= 1'b0;
            alarm_s    <= 1'b0;
            alarm_r    <= 1'b0;
            prev_mode  <= 1'b1;
            prev_inc   <= 1'b1;
            prev_alarm <= 1'b1;
            idle_cnt   <= '0;
            hold_cnt   <= '0;
        end else begin
            prev_mode  <= btn_mode;
            prev_inc   <= btn_inc;
            prev_alarm <= btn_alarm;
            inc_hr     <= 1'b0;
            inc_min    <= 1'b0;
            alarm_s    <= alarm_edge_c & ~alarm_q;
            alarm_r    <= alarm_edge_c & alarm_q;

            if (mode_edge_c) begin
                // Mode edge takes priority over any same-cycle increment.
                state    <= state_nxt_c;
                run_en   <= (state_nxt_c == RUN);
                blink    <= (state_nxt_c != RUN);
                idle_cnt <= '0;
                hold_cnt <= '0;
            end else if (state == RUN) begin
                blink    <= 1'b0;
                idle_cnt <= '0;
                hold_cnt <= '0;
            end else if (inc_edge_c) begin
                inc_hr   <= (state == SET_HR);
                inc_min  <= (state == SET_MIN);
                idle_cnt <= '0;
                hold_cnt <= '0;
                if (tick) begin
                    blink <= ~blink;
                end
            end else begin
                if (tick) begin
                    blink <= ~blink;
                end

                // Auto-repeat while held; reload keeps later pulses REPEAT_RATE apart.
                if (!btn_inc) begin
                    hold_cnt <= '0;
                end else if (tick) begin
                    if (hold_cnt + CNT_W'(1) == DLY_LAST) begin
                        inc_hr   <= (state == SET_HR);
                        inc_min  <= (state == SET_MIN);
                        hold_cnt <= DLY_RELD;
                    end else begin
                        hold_cnt <= hold_cnt + CNT_W'(1);
                    end
                end

                if (tick && !btn_inc) begin
                    if (idle_cnt == IDLE_LAST) begin
                        state    <= RUN;
                        run_en   <= 1'b1;
                        blink    <= 1'b0;
                        idle_cnt <= '0;
                        hold_cnt <= '0;
                    end else begin
                        idle_cnt <= idle_cnt + CNT_W'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed bench for clock_set_ctrl: vector table plus hand-written
// sequences for auto-repeat, timeout and mid-pulse reset.
module tb_clock_set_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick, btn_mode, btn_inc, btn_alarm, alarm_q;
    logic [1:0] mode;
    logic       run_en, blink, inc_hr, inc_min, alarm_s, alarm_r;

    int total = 0;
    int bad   = 0;

    clock_set_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .tick      (tick),
        .btn_mode  (btn_mode),
        .btn_inc   (btn_inc),
        .btn_alarm (btn_alarm),
        .alarm_q   (alarm_q),
        .mode      (mode),
        .run_en    (run_en),
        .blink     (blink),
        .inc_hr    (inc_hr),
        .inc_min   (inc_min),
        .alarm_s   (alarm_s),
        .alarm_r   (alarm_r)
    );

    always #5 clk = ~clk;

    // Expected word layout: {mode[1:0], run_en, blink, inc_hr, inc_min, alarm_s, alarm_r}
    typedef struct {
        logic       m, i, a, q, t;
        logic [7:0] exp;
    } vec_t;

    vec_t tbl [21];

    function automatic logic [7:0] outs();
        return {mode, run_en, blink, inc_hr, inc_min, alarm_s, alarm_r};
    endfunction

    function automatic vec_t mk(logic m, logic i, logic a, logic q, logic t, logic [7:0] e);
        vec_t v;
        v.m = m; v.i = i; v.a = a; v.q = q; v.t = t; v.exp = e;
        return v;
    endfunction

    task automatic drive(input logic m, input logic i, input logic a, input logic q, input logic t);
        btn_mode = m; btn_inc = i; btn_alarm = a; alarm_q = q; tick = t;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%b want=%b", name, act, exp);
        end
    endtask

    int pulses;

    initial begin
        tbl[0]  = mk(0,0,0,0,0, 8'b00_10_0000);
        tbl[1]  = mk(1,0,0,0,0, 8'b01_01_0000);
        tbl[2]  = mk(1,0,0,0,0, 8'b01_01_0000);
        tbl[3]  = mk(0,0,0,0,0, 8'b01_01_0000);
        tbl[4]  = mk(0,1,0,0,0, 8'b01_01_1000);
        tbl[5]  = mk(0,1,0,0,0, 8'b01_01_0000);
        tbl[6]  = mk(0,1,0,0,0, 8'b01_01_0000);
        tbl[7]  = mk(0,0,0,0,1, 8'b01_00_0000);
        tbl[8]  = mk(0,0,1,0,0, 8'b01_00_0010);
        tbl[9]  = mk(0,0,1,0,0, 8'b01_00_0000);
        tbl[10] = mk(0,0,0,1,0, 8'b01_00_0000);
        tbl[11] = mk(0,0,1,1,0, 8'b01_00_0001);
        tbl[12] = mk(0,0,0,1,0, 8'b01_00_0000);
        tbl[13] = mk(1,1,0,0,0, 8'b10_01_0000);
        tbl[14] = mk(0,0,0,0,0, 8'b10_01_0000);
        tbl[15] = mk(0,1,0,0,0, 8'b10_01_0100);
        tbl[16] = mk(0,0,0,0,0, 8'b10_01_0000);
        tbl[17] = mk(1,0,0,0,0, 8'b00_10_0000);
        tbl[18] = mk(0,1,0,0,1, 8'b00_10_0000);
        tbl[19] = mk(0,0,1,0,0, 8'b00_10_0010);
        tbl[20] = mk(0,0,0,0,0, 8'b00_10_0000);

        // Reset with btn_mode held: release must not create an edge.
        reset = 1'b1;
        drive(1,0,0,0,0);
        step(); step();
        chk("reset_vals", outs(), 8'b00_10_0000);
        reset = 1'b0;
        step();
        chk("held_mode_no_edge0", outs(), 8'b00_10_0000);
        step();
        chk("held_mode_no_edge1", outs(), 8'b00_10_0000);

        for (int k = 0; k < 21; k++) begin
            drive(tbl[k].m, tbl[k].i, tbl[k].a, tbl[k].q, tbl[k].t);
            step();
            chk($sformatf("vec%0d", k), outs(), tbl[k].exp);
        end

        // Auto-repeat in SET_MIN across 14 ticks.
        drive(1,0,0,0,0); step();
        drive(0,0,0,0,0); step();
        drive(1,0,0,0,0); step();
        drive(0,0,0,0,0); step();
        chk("enter_set_min", outs(), 8'b10_01_0000);
        drive(0,1,0,0,0); step();
        pulses = int'(inc_min);
        chk("rpt_edge_pulse", {7'd0, inc_min}, 8'd1);
        for (int k = 1; k <= 14; k++) begin
            drive(0,1,0,0,1); step();
            pulses += int'(inc_min);
            chk($sformatf("rpt_tick%0d", k), {7'd0, inc_min}, {7'd0, (k >= 8 && k % 2 == 0)});
            drive(0,1,0,0,0); step();
            chk($sformatf("rpt_gap%0d", k), {7'd0, inc_min}, 8'd0);
        end
        chk("rpt_count", 8'(pulses), 8'd5);
        chk("rpt_mode_held", {6'd0, mode}, 8'd2);
        drive(0,0,0,0,0); step();

        // Idle timeout from SET_HR after 16 ticks.
        drive(1,0,0,0,0); step();
        drive(0,0,0,0,0); step();
        drive(1,0,0,0,0); step();
        drive(0,0,0,0,0); step();
        chk("enter_set_hr", outs(), 8'b01_01_0000);
        for (int k = 1; k <= 16; k++) begin
            drive(0,0,0,0,1); step();
            if (k == 16)
                chk("timeout_run", outs(), 8'b00_10_0000);
            else if (k == 15)
                chk("timeout_pre", outs(), 8'b01_00_0000);
            drive(0,0,0,0,0); step();
        end

        // 15 ticks, then an inc edge on the would-be timeout tick.
        drive(1,0,0,0,0); step();
        drive(0,0,0,0,0); step();
        for (int k = 1; k <= 15; k++) begin
            drive(0,0,0,0,1); step();
            drive(0,0,0,0,0); step();
        end
        chk("pre_edge_set_hr", {6'd0, mode}, 8'd1);
        drive(0,1,0,0,1); step();
        chk("edge_beats_timeout", outs(), 8'b01_01_1000);
        drive(0,0,0,0,0); step();
        for (int k = 1; k <= 3; k++) begin
            drive(0,0,0,0,1); step();
            drive(0,0,0,0,0); step();
        end
        chk("idle_restarted", {6'd0, mode}, 8'd1);

        // Reset during an increment pulse in SET_MIN.
        drive(1,0,0,0,0); step();
        drive(0,0,0,0,0); step();
        drive(0,1,0,0,0); step();
        chk("pulse_before_reset", outs(), 8'b10_01_0100);
        reset = 1'b1;
        drive(0,0,0,0,0);
        #1;
        chk("reset_async", outs(), 8'b00_10_0000);
        step();
        reset = 1'b0;
        step();
        chk("after_reset", outs(), 8'b00_10_0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
